ysyx_24110026_idu: RTL and testbench

//  Decode/issue stage feeding the execute ALU. Takes fetched RV32E instructions (valid/ready),

---
 rtl/ysyx_24110026_idu.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ysyx_24110026_idu.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110026_idu.sv
// ysyx_24110026_idu -- RV32E decode/issue stage for the integer ALU subset.
//
// Accepts instruction words from the fetch unit (in_valid/in_ready), decodes
// OP / OP-IMM / LUI into a one-hot ALU operation, reads operands from the
// register file, and holds the result in a single output register toward the
// execute unit (out_valid/out_ready). A per-register busy scoreboard stalls
// issue on read-after-write hazards until writeback retires the destination.
//
// Optional feature macro: IDU_ILLEGAL_TRAP_EN
//   defined   : an illegal instruction is accepted but not issued; illegal
//               goes high and the stage stops accepting until reset.
//   undefined : an illegal instruction issues as a NOP (alu_op=0, rd=0,
//               operands 0) and illegal is tied low.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_inst  instruction handshake from IFU
//   rf_raddr1/2, rf_rdata1/2   register file read (combinational data)
//   wb_valid, wb_rd            writeback retiring register wb_rd
//   out_valid/out_ready        decoded-op handshake toward EXU
//   alu_op                     one-hot: add,sub,xor,or,and,srl,sll,sra (b0..b7)
//   rs1_data, rs2_data, rd     ALU operands and destination register
//   illegal                    illegal instruction trapped
module ysyx_24110026_idu #(
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic [3:0]      rf_raddr1,
  output logic [3:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [3:0]      wb_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      alu_op,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [3:0]      rd,
  output logic            illegal
);

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_SUB = 8'h02;
  localparam logic [7:0] OP_XOR = 8'h04;
  localparam logic [7:0] OP_OR  = 8'h08;
  localparam logic [7:0] OP_AND = 8'h10;
  localparam logic [7:0] OP_SRL = 8'h20;
  localparam logic [7:0] OP_SLL = 8'h40;
  localparam logic [7:0] OP_SRA = 8'h80;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_TRAP} state_t;

  state_t r_state;
  state_t w_state_next;

  // instruction fields
  logic [6:0] w_opcode;
  logic [4:0] w_rd_f;
  logic [2:0] w_f3;
  logic [4:0] w_rs1_f;
  logic [4:0] w_rs2_f;
  logic [6:0] w_f7;

  assign w_opcode = in_inst[6:0];
  assign w_rd_f   = in_inst[11:7];
  assign w_f3     = in_inst[14:12];
  assign w_rs1_f  = in_inst[19:15];
  assign w_rs2_f  = in_inst[24:20];
  assign w_f7     = in_inst[31:25];

  assign rf_raddr1 = in_inst[18:15];
  assign rf_raddr2 = in_inst[23:20];

  logic            w_legal;
  logic            w_uses1;
  logic            w_uses2;
  logic [7:0]      w_op;
  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic [3:0]      w_dst;

  // Decode. Anything not explicitly recognised stays illegal; an illegal
  // instruction reads no registers, so it never stalls on the scoreboard.
  always_comb begin
    w_legal = 1'b0;
    w_uses1 = 1'b0;
    w_uses2 = 1'b0;
    w_op    = 8'h00;
    w_opa   = '0;
    w_opb   = '0;
    case (w_opcode)
      7'b0110011: begin
        w_uses1 = 1'b1;
        w_uses2 = 1'b1;
        w_opa   = rf_rdata1;
        w_opb   = rf_rdata2;
        case (w_f3)
          3'd0: begin
            if (w_f7 == 7'h00) begin w_op = OP_ADD; w_legal = 1'b1; end
            else if (w_f7 == 7'h20) begin w_op = OP_SUB; w_legal = 1'b1; end
          end
          3'd1: if (w_f7 == 7'h00) begin w_op = OP_SLL; w_legal = 1'b1; end
          3'd4: if (w_f7 == 7'h00) begin w_op = OP_XOR; w_legal = 1'b1; end
          3'd5: begin
            if (w_f7 == 7'h00) begin w_op = OP_SRL; w_legal = 1'b1; end
            else if (w_f7 == 7'h20) begin w_op = OP_SRA; w_legal = 1'b1; end
          end
          3'd6: if (w_f7 == 7'h00) begin w_op = OP_OR;  w_legal = 1'b1; end
          3'd7: if (w_f7 == 7'h00) begin w_op = OP_AND; w_legal = 1'b1; end
          default: ;
        endcase
        // RV32E has only x0..x15
        if (w_rs1_f[4] | w_rs2_f[4] | w_rd_f[4]) w_legal = 1'b0;
      end
      7'b0010011: begin
        w_uses1 = 1'b1;
        w_opa   = rf_rdata1;
        w_opb   = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
        case (w_f3)
          3'd0: begin w_op = OP_ADD; w_legal = 1'b1; end
          3'd4: begin w_op = OP_XOR; w_legal = 1'b1; end
          3'd6: begin w_op = OP_OR;  w_legal = 1'b1; end
          3'd7: begin w_op = OP_AND; w_legal = 1'b1; end
          3'd1: begin
            w_opb = {{(XLEN-5){1'b0}}, in_inst[24:20]};
            if (w_f7 == 7'h00) begin w_op = OP_SLL; w_legal = 1'b1; end
          end
          3'd5: begin
            w_opb = {{(XLEN-5){1'b0}}, in_inst[24:20]};
            if (w_f7 == 7'h00) begin w_op = OP_SRL; w_legal = 1'b1; end
            else if (w_f7 == 7'h20) begin w_op = OP_SRA; w_legal = 1'b1; end
          end
          default: ;
        endcase
        if (w_rs1_f[4] | w_rd_f[4]) w_legal = 1'b0;
      end
      7'b0110111: begin
        // LUI executes as 0 + (imm << 12)
        w_op    = OP_ADD;
        w_opb   = {in_inst[31:12], 12'b0};
        w_legal = ~w_rd_f[4];
      end
      default: ;
    endcase
    if (!w_legal) begin
      w_uses1 = 1'b0;
      w_uses2 = 1'b0;
      w_op    = 8'h00;
      w_opa   = '0;
      w_opb   = '0;
    end
  end

  assign w_dst = w_legal ? w_rd_f[3:0] : 4'd0;

  // scoreboard
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;
  logic            w_stall;
  logic            w_accept;
  logic            w_issue;
  logic            w_trap_acc;

  assign w_stall = in_valid & ((r_busy[rf_raddr1] & w_uses1) |
                               (r_busy[rf_raddr2] & w_uses2));

  assign w_accept = in_valid & in_ready;

`ifdef IDU_ILLEGAL_TRAP_EN
  assign w_trap_acc = w_accept & ~w_legal;
  assign w_issue    = w_accept & w_legal;
`else
  assign w_trap_acc = 1'b0;
  assign w_issue    = w_accept;
`endif

  // Setting on issue takes priority over a same-cycle writeback clear, since
  // the newly issued producer has not yet written the register. x0 is never busy.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign w_busy_next[gi] = 1'b0;
      end else begin : g_reg
        assign w_busy_next[gi] = (w_issue & (w_dst == 4'(gi))) |
                                 (r_busy[gi] & ~(wb_valid & (wb_rd == 4'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_next;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_EMPTY;
    else      r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_trap_acc)   w_state_next = S_TRAP;
        else if (w_issue) w_state_next = S_FULL;
      end
      S_FULL: begin
        if (w_trap_acc)     w_state_next = S_TRAP;
        else if (w_issue)   w_state_next = S_FULL;
        else if (out_ready) w_state_next = S_EMPTY;
      end
      S_TRAP:  w_state_next = S_TRAP;
      default: w_state_next = S_EMPTY;
    endcase
  end

  // FSM: outputs. An accept always consumes any pending op, so entering TRAP
  // leaves nothing valid downstream.
  always_comb begin
    out_valid = (r_state == S_FULL);
    in_ready  = ~w_stall & (~out_valid | out_ready) & (r_state != S_TRAP);
  end

  // output pipeline register
  logic [7:0]      r_alu_op;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [3:0]      r_rd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_op   <= 8'h00;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rd       <= 4'd0;
    end else if (w_issue) begin
      r_alu_op   <= w_op;
      r_rs1_data <= w_opa;
      r_rs2_data <= w_opb;
      r_rd       <= w_dst;
    end
  end

  assign alu_op   = r_alu_op;
  assign rs1_data = r_rs1_data;
  assign rs2_data = r_rs2_data;
  assign rd       = r_rd;

`ifdef IDU_ILLEGAL_TRAP_EN
  logic r_illegal;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_illegal <= 1'b0;
    else if (w_trap_acc) r_illegal <= 1'b1;
  end
  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24110026_idu.sv
// Testbench for ysyx_24110026_idu: directed cases from the decode/issue rules
// followed by randomized traffic, checked against a transaction-level model.
module tb_ysyx_24110026_idu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [3:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  alu_op;
  logic [31:0] rs1_data, rs2_data;
  logic [3:0]  rd;
  logic        illegal;

  always #5 clk = ~clk;

  ysyx_24110026_idu dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .rs1_data(rs1_data), .rs2_data(rs2_data), .rd(rd),
    .illegal(illegal)
  );

`ifdef IDU_ILLEGAL_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  // register file contents seen by the decoder
  logic [31:0] rf_val [16];
  assign rf_rdata1 = rf_val[rf_raddr1];
  assign rf_rdata2 = rf_val[rf_raddr2];

  // one instruction together with what it should turn into
  typedef struct packed {
    logic [31:0] inst;
    logic        legal;
    logic        u1;
    logic        u2;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [3:0]  rd;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } desc_t;

  // model state
  logic  m_full, m_trap, m_illegal;
  logic  m_busy [16];
  desc_t m_out;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Kinds: 0 ADD 1 SUB 2 XOR 3 OR 4 AND 5 SLL 6 SRL 7 SRA 8 ADDI 9 XORI
  // 10 ORI 11 ANDI 12 SLLI 13 SRLI 14 SRAI 15 LUI, 16..23 illegal forms.
  function automatic desc_t mk(input int kind, input int rdi, input int rs1i,
                               input int rs2i, input logic [31:0] imm);
    desc_t d;
    logic [4:0] rd5, s1, s2;
    rd5 = 5'(rdi & 15);
    s1  = 5'(rs1i & 15);
    s2  = 5'(rs2i & 15);
    d = '0;
    d.legal = 1'b1;
    d.rd  = rd5[3:0];
    d.rs1 = s1[3:0];
    d.rs2 = s2[3:0];
    case (kind)
      0:  begin d.inst = {7'h00, s2, s1, 3'd0, rd5, 7'h33}; d.op = 8'h01; end
      1:  begin d.inst = {7'h20, s2, s1, 3'd0, rd5, 7'h33}; d.op = 8'h02; end
      2:  begin d.inst = {7'h00, s2, s1, 3'd4, rd5, 7'h33}; d.op = 8'h04; end
      3:  begin d.inst = {7'h00, s2, s1, 3'd6, rd5, 7'h33}; d.op = 8'h08; end
      4:  begin d.inst = {7'h00, s2, s1, 3'd7, rd5, 7'h33}; d.op = 8'h10; end
      5:  begin d.inst = {7'h00, s2, s1, 3'd1, rd5, 7'h33}; d.op = 8'h40; end
      6:  begin d.inst = {7'h00, s2, s1, 3'd5, rd5, 7'h33}; d.op = 8'h20; end
      7:  begin d.inst = {7'h20, s2, s1, 3'd5, rd5, 7'h33}; d.op = 8'h80; end
      8:  begin d.inst = {imm[11:0], s1, 3'd0, rd5, 7'h13}; d.op = 8'h01; end
      9:  begin d.inst = {imm[11:0], s1, 3'd4, rd5, 7'h13}; d.op = 8'h04; end
      10: begin d.inst = {imm[11:0], s1, 3'd6, rd5, 7'h13}; d.op = 8'h08; end
      11: begin d.inst = {imm[11:0], s1, 3'd7, rd5, 7'h13}; d.op = 8'h10; end
      12: begin d.inst = {7'h00, imm[4:0], s1, 3'd1, rd5, 7'h13}; d.op = 8'h40; end
      13: begin d.inst = {7'h00, imm[4:0], s1, 3'd5, rd5, 7'h13}; d.op = 8'h20; end
      14: begin d.inst = {7'h20, imm[4:0], s1, 3'd5, rd5, 7'h13}; d.op = 8'h80; end
      15: begin d.inst = {imm[19:0], rd5, 7'h37}; d.op = 8'h01; end
      16: d.inst = {7'h00, s2, s1, 3'd2, rd5, 7'h33};               // SLT
      17: d.inst = {imm[11:0], s1, 3'd3, rd5, 7'h13};               // SLTIU
      18: d.inst = {imm[11:0], 1'b1, s1[3:0], 3'd0, rd5, 7'h13};    // ADDI rs1>=16
      19: d.inst = {imm[11:0], s1, 3'd0, 5'h10, 7'h13};             // ADDI rd=16
      20: d.inst = {7'h20, s2, s1, 3'd4, rd5, 7'h33};               // XOR bad funct7
      21: d.inst = {7'h20, imm[4:0], s1, 3'd1, rd5, 7'h13};         // SLLI bad funct7
      22: d.inst = {imm[11:0], s1, 3'd2, rd5, 7'h03};               // load
      default: d.inst = {7'h00, 1'b1, s2[3:0], s1, 3'd0, rd5, 7'h33}; // ADD rs2>=16
    endcase
    if (kind < 8) begin
      d.u1 = 1'b1; d.u2 = 1'b1;
      d.a = rf_val[s1[3:0]]; d.b = rf_val[s2[3:0]];
    end else if (kind < 12) begin
      d.u1 = 1'b1;
      d.a = rf_val[s1[3:0]]; d.b = {{20{imm[11]}}, imm[11:0]};
    end else if (kind < 15) begin
      d.u1 = 1'b1;
      d.a = rf_val[s1[3:0]]; d.b = {27'b0, imm[4:0]};
    end else if (kind == 15) begin
      d.a = 32'h0; d.b = {imm[19:0], 12'h000};
    end else begin
      d.legal = 1'b0; d.op = 8'h00; d.rd = 4'd0; d.a = 32'h0; d.b = 32'h0;
    end
    return d;
  endfunction

  task automatic model_reset();
    m_full = 1'b0; m_trap = 1'b0; m_illegal = 1'b0; m_out = '0;
    for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance model,
  // return at the next posedge+1.
  task automatic cycle(input logic v, input desc_t d, input logic ordy,
                       input logic wv, input logic [3:0] wrd);
    logic stall, exp_rdy, acc;
    in_valid  = v;
    in_inst   = d.inst;
    out_ready = ordy;
    wb_valid  = wv;
    wb_rd     = wrd;
    stall   = v && ((d.u1 && m_busy[d.rs1]) || (d.u2 && m_busy[d.rs2]));
    exp_rdy = !m_trap && (!m_full || ordy) && !stall;
    @(negedge clk);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_full});
    chk("illegal", {31'b0, illegal}, {31'b0, m_illegal});
    if (m_full) begin
      chk("alu_op", {24'b0, alu_op}, {24'b0, m_out.op});
      chk("rs1_data", rs1_data, m_out.a);
      chk("rs2_data", rs2_data, m_out.b);
      chk("rd", {28'b0, rd}, {28'b0, m_out.rd});
    end
    acc = v && exp_rdy;
    if (wv && wrd != 4'd0) m_busy[wrd] = 1'b0;
    if (acc && d.legal && d.rd != 4'd0) m_busy[d.rd] = 1'b1;
    if (acc) begin
      if (!d.legal && TRAP_ON) begin
        m_trap = 1'b1; m_illegal = 1'b1; m_full = 1'b0;
      end else begin
        m_full = 1'b1; m_out = d;
      end
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_inst = 32'h0; out_ready = 1'b0; wb_valid = 1'b0; wb_rd = 4'd0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    desc_t d, dadd, dsub, dx, dr, dil;
    logic  v, ordy, wv;
    logic [3:0] wrd;
    int    k, off;

    for (int i = 0; i < 16; i++) rf_val[i] = $urandom;
    rf_val[0] = 32'h0;
    rf_val[1] = 32'h8000_0000;

    // reset values while reset is held
    in_valid = 1'b0; in_inst = 32'h0; out_ready = 1'b0; wb_valid = 1'b0; wb_rd = 4'd0;
    rst = 1'b0;
    model_reset();
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_alu_op", {24'b0, alu_op}, 32'h0);
    chk("reset_rs1_data", rs1_data, 32'h0);
    chk("reset_rs2_data", rs2_data, 32'h0);
    chk("reset_rd", {28'b0, rd}, 32'h0);
    chk("reset_illegal", {31'b0, illegal}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // ADDI x1,x0,5
    d = mk(8, 1, 0, 0, 5);
    cycle(1'b1, d, 1'b1, 1'b0, 4'd0);
    $display("addi x1,x0,5 inst=%08h alu_op=%02h A=%08h B=%08h rd=%0d", d.inst, alu_op, rs1_data, rs2_data, rd);
    chk("addi_valid", {31'b0, out_valid}, 32'h1);
    chk("addi_op", {24'b0, alu_op}, 32'h01);
    chk("addi_a", rs1_data, 32'h0);
    chk("addi_b", rs2_data, 32'h5);
    chk("addi_rd", {28'b0, rd}, 32'h1);

    // ADD x3,x1,x2 stalls on busy x1 until writeback of x1
    dadd = mk(0, 3, 1, 2, 0);
    cycle(1'b1, dadd, 1'b1, 1'b0, 4'd0);
    chk("raw_stall", {31'b0, in_ready}, 32'h0);
    cycle(1'b1, dadd, 1'b1, 1'b0, 4'd0);
    cycle(1'b1, dadd, 1'b1, 1'b1, 4'd1);
    chk("raw_release", {31'b0, in_ready}, 32'h1);
    cycle(1'b1, dadd, 1'b1, 1'b0, 4'd0);
    $display("add x3,x1,x2 inst=%08h alu_op=%02h rd=%0d", dadd.inst, alu_op, rd);
    chk("add_op", {24'b0, alu_op}, 32'h01);
    chk("add_a", rs1_data, rf_val[1]);
    chk("add_b", rs2_data, rf_val[2]);
    chk("add_rd", {28'b0, rd}, 32'h3);

    // SRAI x5,x1,3 with x1 = 0x80000000
    d = mk(14, 5, 1, 0, 3);
    cycle(1'b1, d, 1'b1, 1'b0, 4'd0);
    $display("srai x5,x1,3 inst=%08h alu_op=%02h A=%08h B=%08h", d.inst, alu_op, rs1_data, rs2_data);
    chk("srai_op", {24'b0, alu_op}, 32'h80);
    chk("srai_a", rs1_data, 32'h8000_0000);
    chk("srai_b", rs2_data, 32'h3);
    chk("srai_rd", {28'b0, rd}, 32'h5);

    // SUB x3,x1,x2
    dsub = mk(1, 3, 1, 2, 0);
    cycle(1'b1, dsub, 1'b1, 1'b0, 4'd0);
    $display("sub x3,x1,x2 inst=%08h alu_op=%02h", dsub.inst, alu_op);
    chk("sub_op", {24'b0, alu_op}, 32'h02);

    // backpressure: held op stays stable and nothing is accepted
    dx = mk(2, 7, 2, 4, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, dx, 1'b0, 1'b0, 4'd0);
      $display("backpressure cycle %0d alu_op=%02h in_ready=%0b", i, alu_op, in_ready);
      chk("bp_op", {24'b0, alu_op}, 32'h02);
      chk("bp_rd", {28'b0, rd}, 32'h3);
    end
    cycle(1'b1, dx, 1'b1, 1'b0, 4'd0);
    chk("b2b_xor_op", {24'b0, alu_op}, 32'h04);
    chk("b2b_xor_rd", {28'b0, rd}, 32'h7);
    d = mk(3, 8, 2, 4, 0);
    cycle(1'b1, d, 1'b1, 1'b0, 4'd0);
    $display("back-to-back or x8 alu_op=%02h rd=%0d", alu_op, rd);
    chk("b2b_or_op", {24'b0, alu_op}, 32'h08);
    chk("b2b_or_valid", {31'b0, out_valid}, 32'h1);

    // retire outstanding destinations
    for (int r = 3; r <= 8; r++) cycle(1'b0, dx, 1'b1, 1'b1, 4'(r));

    // set and clear of the same register in one cycle: set wins
    cycle(1'b1, mk(8, 6, 0, 0, 1), 1'b1, 1'b0, 4'd0);
    cycle(1'b1, mk(8, 6, 0, 0, 2), 1'b1, 1'b1, 4'd6);
    dr = mk(0, 9, 6, 0, 0);
    cycle(1'b1, dr, 1'b1, 1'b0, 4'd0);
    $display("set+clear x6 same cycle, reader in_ready=%0b", in_ready);
    chk("setwins_stall", {31'b0, in_ready}, 32'h0);
    cycle(1'b1, dr, 1'b1, 1'b1, 4'd6);
    cycle(1'b1, dr, 1'b1, 1'b0, 4'd0);
    chk("setwins_issue_rd", {28'b0, rd}, 32'h9);
    cycle(1'b0, dr, 1'b1, 1'b1, 4'd9);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      k = int'($urandom_range(0, 15));
      if (!TRAP_ON && $urandom_range(0, 9) == 0) k = int'($urandom_range(16, 23));
      d = mk(k, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)), $urandom);
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      wv   = ($urandom_range(0, 2) == 0);
      wrd  = 4'($urandom_range(0, 15));
      off  = int'($urandom_range(0, 15));
      for (int j = 0; j < 16; j++) begin
        if (m_busy[(j + off) % 16]) wrd = 4'((j + off) % 16);
      end
      cycle(v, d, ordy, wv, wrd);
      $display("rand %0d kind=%0d v=%0b inst=%08h ordy=%0b wb=%0b/%0d out_valid=%0b alu_op=%02h rd=%0d",
               i, k, v, d.inst, ordy, wv, wrd, out_valid, alu_op, rd);
    end
    cycle(1'b0, d, 1'b1, 1'b0, 4'd0);

    // ADDI x16,x0,1 -- register index out of range
    dil = mk(19, 0, 0, 0, 1);
    cycle(1'b1, dil, 1'b1, 1'b0, 4'd0);
    $display("illegal inst=%08h out_valid=%0b illegal=%0b alu_op=%02h rd=%0d", dil.inst, out_valid, illegal, alu_op, rd);
`ifdef IDU_ILLEGAL_TRAP_EN
    chk("trap_illegal", {31'b0, illegal}, 32'h1);
    chk("trap_no_issue", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, mk(8, 2, 0, 0, 1), 1'b1, 1'b0, 4'd0);
      chk("trap_in_ready", {31'b0, in_ready}, 32'h0);
    end
`else
    chk("nop_valid", {31'b0, out_valid}, 32'h1);
    chk("nop_op", {24'b0, alu_op}, 32'h0);
    chk("nop_rd", {28'b0, rd}, 32'h0);
    chk("nop_a", rs1_data, 32'h0);
    chk("nop_b", rs2_data, 32'h0);
    chk("nop_illegal", {31'b0, illegal}, 32'h0);
`endif

    // asynchronous reset while FULL with x3 busy
    do_reset();
    cycle(1'b1, mk(0, 3, 1, 2, 0), 1'b0, 1'b0, 4'd0);
    chk("pre_reset_full", {31'b0, out_valid}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    $display("async reset mid-cycle out_valid=%0b alu_op=%02h rd=%0d", out_valid, alu_op, rd);
    chk("async_out_valid", {31'b0, out_valid}, 32'h0);
    chk("async_alu_op", {24'b0, alu_op}, 32'h0);
    chk("async_rd", {28'b0, rd}, 32'h0);
    chk("async_rs1", rs1_data, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    d = mk(0, 4, 3, 0, 0);
    cycle(1'b1, d, 1'b1, 1'b0, 4'd0);
    $display("after reset add x4,x3,x0 out_valid=%0b rd=%0d", out_valid, rd);
    chk("post_reset_issue", {31'b0, out_valid}, 32'h1);
    chk("post_reset_rd", {28'b0, rd}, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
